// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: command inputs and BCD display outputs of the stopwatch.
interface stopwatch_ctrl_if;
  logic       start;
  logic       stop;
  logic       clear;
  logic [3:0] secOnes;
  logic [2:0] secTens;
  logic [3:0] minOnes;
  logic       running;
  logic       overflow;
  modport master (output start, stop, clear, input secOnes, secTens, minOnes, running, overflow);
  modport slave  (input start, stop, clear, output secOnes, secTens, minOnes, running, overflow);
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: prescaled M:SS stopwatch with IDLE/RUN/HOLD control.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 4
) (
  input  logic              sysClk,
  input  logic              sysRst,
  stopwatch_ctrl_if.slave   sw
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;
  localparam logic [7:0] LAST = 8'(TICK_DIV - 1);
  state_t     r_state;
  logic [7:0] r_pre;
  logic [3:0] r_s1;
  logic [2:0] r_s10;
  logic [3:0] r_m;
  logic       r_running;
  logic       r_ovf;
  logic       w_s1_wrap;
  logic       w_s10_wrap;
  logic       w_m_wrap;
  assign w_s1_wrap  = r_s1 == 4'd9;
  assign w_s10_wrap = r_s10 == 3'd5;
  assign w_m_wrap   = r_m == 4'd9;
  always_ff @(posedge sysClk) begin
    if (sysRst) begin
      r_state   <= IDLE;
      r_pre     <= '0;
      r_s1      <= '0;
      r_s10     <= '0;
      r_m       <= '0;
      r_running <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_ovf <= 1'b0;
      if (sw.clear) begin
        r_state   <= IDLE;
        r_pre     <= '0;
        r_s1      <= '0;
        r_s10     <= '0;
        r_m       <= '0;
        r_running <= 1'b0;
      end else if (sw.stop) begin
        if (r_state == RUN) begin
          r_state   <= HOLD;
          r_running <= 1'b0;
        end
      end else if (r_state != RUN) begin
        if (sw.start) begin
          r_state   <= RUN;
          r_running <= 1'b1;
        end
      end else if (r_pre == LAST) begin
        // all digits of one tick settle together, so no illegal value is ever shown
        r_pre <= '0;
        r_s1  <= w_s1_wrap ? 4'd0 : r_s1 + 4'd1;
        if (w_s1_wrap) r_s10 <= w_s10_wrap ? 3'd0 : r_s10 + 3'd1;
        if (w_s1_wrap && w_s10_wrap) r_m <= w_m_wrap ? 4'd0 : r_m + 4'd1;
        r_ovf <= w_s1_wrap && w_s10_wrap && w_m_wrap;
      end else begin
        r_pre <= r_pre + 8'd1;
      end
    end
  end
  assign sw.secOnes  = r_s1;
  assign sw.secTens  = r_s10;
  assign sw.minOnes  = r_m;
  assign sw.running  = r_running;
  assign sw.overflow = r_ovf;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed and random checks against a seconds-count reference model.
module tb_stopwatch_ctrl;
  localparam int TD = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   m_state = 0;
  int   m_secs = 0;
  int   m_pre = 0;
  bit   m_ovf = 1'b0;
  int   saved;
  stopwatch_ctrl_if sw ();
  stopwatch_ctrl #(.TICK_DIV(TD)) dut (.sysClk(clk), .sysRst(rst), .sw(sw.slave));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("secOnes",  32'(sw.secOnes), 32'(m_secs % 10));
    chk("secTens",  32'(sw.secTens), 32'((m_secs % 60) / 10));
    chk("minOnes",  32'(sw.minOnes), 32'(m_secs / 60));
    chk("running",  32'(sw.running), 32'(m_state == 1));
    chk("overflow", 32'(sw.overflow), 32'(m_ovf));
  endtask

  // Reference: the count is total elapsed seconds modulo ten minutes.
  task automatic model_step(input bit r, input bit t, input bit s, input bit c);
    m_ovf = 1'b0;
    if (r || c) begin
      m_state = 0; m_secs = 0; m_pre = 0;
    end else if (s) begin
      if (m_state == 1) m_state = 2;
    end else if (m_state != 1) begin
      if (t) m_state = 1;
    end else if (m_pre == TD - 1) begin
      m_pre = 0;
      m_secs = (m_secs + 1) % 600;
      m_ovf = (m_secs == 0);
    end else begin
      m_pre++;
    end
  endtask

  task automatic cyc(input bit t, input bit s, input bit c, input bit r);
    sw.start = t; sw.stop = s; sw.clear = c; rst = r;
    @(posedge clk);
    model_step(r, t, s, c);
    @(negedge clk);
    check_model();
  endtask

  task automatic run_until(input int secs, input int pre);
    int n = 0;
    while (!((secs < 0 || m_secs == secs) && m_pre == pre) && n < 5000) begin
      cyc(0, 0, 0, 0);
      n++;
    end
    chk("run_until_budget", 32'(n < 5000), 32'd1);
  endtask

  initial begin
    sw.start = 0; sw.stop = 0; sw.clear = 0;
    @(negedge clk);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 1, 1);
    chk("reset_running", 32'(sw.running), 32'd0);
    cyc(1, 0, 0, 0);
    chk("start_running", 32'(sw.running), 32'd1);
    repeat (3) cyc(0, 0, 0, 0);
    chk("sec_before_tick", 32'(sw.secOnes), 32'd0);
    cyc(0, 0, 0, 0);
    chk("sec_first_tick", 32'(sw.secOnes), 32'd1);
    repeat (4) cyc(0, 0, 0, 0);
    chk("sec_second_tick", 32'(sw.secOnes), 32'd2);
    run_until(59, TD - 1);
    cyc(0, 0, 0, 0);
    chk("min_carry_m", 32'(sw.minOnes), 32'd1);
    chk("min_carry_t", 32'(sw.secTens), 32'd0);
    chk("min_carry_ovf", 32'(sw.overflow), 32'd0);
    run_until(599, TD - 1);
    cyc(0, 0, 0, 0);
    chk("wrap_ovf", 32'(sw.overflow), 32'd1);
    chk("wrap_min", 32'(sw.minOnes), 32'd0);
    chk("wrap_running", 32'(sw.running), 32'd1);
    cyc(0, 0, 0, 0);
    chk("wrap_ovf_pulse_end", 32'(sw.overflow), 32'd0);
    run_until(-1, 2);
    saved = m_secs;
    cyc(0, 1, 0, 0);
    repeat (20) cyc(1, 1, 0, 0);
    chk("hold_frozen", 32'(sw.secOnes), 32'(saved % 10));
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("resume_pre3", 32'(sw.secOnes), 32'(saved % 10));
    cyc(0, 0, 0, 0);
    chk("resume_tick", 32'(sw.secOnes), 32'((saved + 1) % 10));
    run_until(205, 0);
    cyc(0, 1, 0, 0);
    chk("hold_325_m", 32'(sw.minOnes), 32'd3);
    cyc(1, 1, 1, 0);
    chk("clear_all_s", 32'(sw.secOnes), 32'd0);
    chk("clear_all_m", 32'(sw.minOnes), 32'd0);
    chk("clear_all_run", 32'(sw.running), 32'd0);
    cyc(1, 0, 0, 0);
    run_until(277, 0);
    cyc(0, 0, 0, 1);
    chk("rst_mid_m", 32'(sw.minOnes), 32'd0);
    repeat (6) cyc(0, 0, 0, 0);
    chk("rst_needs_start", 32'(sw.running), 32'd0);
    repeat (3000)
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0,
          $urandom_range(0, 79) == 0, $urandom_range(0, 299) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
